// File: rtl/mem_bus_resp.sv
// Purpose: word-addressed 16-bit memory slave with byte lanes, address decode and wait states.
// Latency: req sampled at edge E0 -> mem_done high for the cycle after edge E0+WAIT_STATES+1.
// Backpressure: busy high while an access is in flight; req is ignored until busy drops.
module mem_bus_resp #(
  parameter logic [15:0] BASE_ADDR   = 16'h0200,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [15:0] MAB_in,
  input  logic [15:0] MDB_in,
  input  logic        RW,
  input  logic        MD,
  output logic [15:0] MDB_out,
  output logic        mem_done,
  output logic        busy,
  output logic        addr_err
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);
  // Last mapped byte address, computed wide so a window near 16'hFFFF cannot wrap.
  localparam logic [31:0] LAST_ADDR = 32'(BASE_ADDR) + 32'(2 * DEPTH_WORDS) - 32'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic [3:0]  cnt;

  logic [15:0] lat_addr;
  logic [15:0] lat_dat;
  logic        lat_rw;
  logic        lat_md;

  logic [15:0] mem [DEPTH_WORDS];

  logic        mapped;
  logic [15:0] offset;
  logic [IDX_W-1:0] idx;
  logic [15:0] old_word;
  logic [15:0] wr_word;
  logic [15:0] rd_dat;
  logic        wr_en;

  // Next-state decode; a new request is only taken in IDLE.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          state_nxt = (WS == 4'd0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, wait counter and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      MDB_out  <= 16'h0000;
      mem_done <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      mem_done <= (state == ACCESS);
      addr_err <= (state == ACCESS) && !mapped;
      if (accept) begin
        cnt <= WS;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      // Only reads update the read-data register; it holds across writes.
      if ((state == ACCESS) && !lat_rw) begin
        MDB_out <= rd_dat;
      end
    end
  end

  // Operand capture at acceptance; held stable for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr <= 16'h0000;
      lat_dat  <= 16'h0000;
      lat_rw   <= 1'b0;
      lat_md   <= 1'b0;
    end else if (accept) begin
      lat_addr <= MAB_in;
      lat_dat  <= MDB_in;
      lat_rw   <= RW;
      lat_md   <= MD;
    end
  end

  assign busy = (state != IDLE);

  // Address decode against the mapped window.
  assign mapped   = ({16'h0000, lat_addr} >= 32'(BASE_ADDR)) &&
                    ({16'h0000, lat_addr} <= LAST_ADDR);
  assign offset   = lat_addr - BASE_ADDR;
  assign idx      = offset[IDX_W:1];
  assign old_word = mem[idx];

  // Byte writes merge into the addressed lane, keeping the other lane intact.
  always_comb begin
    wr_word = lat_dat;
    if (lat_md) begin
      if (lat_addr[0]) wr_word = {lat_dat[7:0], old_word[7:0]};
      else             wr_word = {old_word[15:8], lat_dat[7:0]};
    end
  end

  // Read data selection, including the fixed pattern returned for unmapped reads.
  always_comb begin
    rd_dat = old_word;
    if (!mapped) begin
      rd_dat = lat_md ? 16'h00FF : 16'h3FFF;
    end else if (lat_md) begin
      rd_dat = {8'h00, (lat_addr[0] ? old_word[15:8] : old_word[7:0])};
    end
  end

  // Gating on rst_n keeps a reset coincident with the closing edge from committing.
  assign wr_en = rst_n && (state == ACCESS) && lat_rw && mapped;

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_mem_bus_resp.sv
// Purpose: directed self-checking bench for mem_bus_resp (one WAIT_STATES=1 and one WAIT_STATES=0 instance).
// Latency: stimulus driven on falling edges, outputs sampled on falling edges.
// Backpressure: accesses wait on busy/mem_done with a bounded cycle budget.
module tb_mem_bus_resp;

  logic        clk;
  logic        rst_n;

  logic        req;
  logic [15:0] mab;
  logic [15:0] mdb;
  logic        rw;
  logic        md;
  logic [15:0] rdat;
  logic        done;
  logic        bsy;
  logic        err;

  logic        req0;
  logic [15:0] mab0;
  logic [15:0] mdb0;
  logic        rw0;
  logic        md0;
  logic [15:0] rdat0;
  logic        done0;
  logic        bsy0;
  logic        err0;

  int checks;
  int errors;

  mem_bus_resp #(.BASE_ADDR(16'h0200), .DEPTH_WORDS(256), .WAIT_STATES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .MAB_in(mab), .MDB_in(mdb), .RW(rw), .MD(md),
    .MDB_out(rdat), .mem_done(done), .busy(bsy), .addr_err(err)
  );

  mem_bus_resp #(.BASE_ADDR(16'h0200), .DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .MAB_in(mab0), .MDB_in(mdb0), .RW(rw0), .MD(md0),
    .MDB_out(rdat0), .mem_done(done0), .busy(bsy0), .addr_err(err0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One access on the WAIT_STATES=1 instance; returns captured response and timing.
  task automatic do_acc(input logic a_rw, input logic a_md, input logic [15:0] a_addr,
                        input logic [15:0] a_dat, output logic [15:0] o_rd,
                        output logic o_err, output int o_lat, output int o_bcyc);
    @(negedge clk);
    req = 1'b1; rw = a_rw; md = a_md; mab = a_addr; mdb = a_dat;
    @(negedge clk);
    req = 1'b0;
    o_lat = -1; o_bcyc = 0; o_rd = 16'hxxxx; o_err = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (done === 1'b1) begin
        o_lat = i; o_rd = rdat; o_err = err;
        break;
      end
      if (bsy === 1'b1) o_bcyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks += 4;
    if (rdat !== 16'h0000) begin errors++; $display("FAIL reset_mdb_out got %h want 0000", rdat); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_mem_done got %b want 0", done); end
    if (bsy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bsy); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got %b want 0", err); end
    checks += 2;
    if (rdat0 !== 16'h0000) begin errors++; $display("FAIL reset_mdb_out0 got %h want 0000", rdat0); end
    if (bsy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %b want 0", bsy0); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    logic [15:0] rd; logic e; int lat; int bc;
    do_acc(1'b1, 1'b0, 16'h0200, 16'hBEEF, rd, e, lat, bc);
    checks += 4;
    if (lat !== 3) begin errors++; $display("FAIL word_wr_latency got %0d want 3", lat); end
    if (bc !== 2) begin errors++; $display("FAIL word_wr_busy_cycles got %0d want 2", bc); end
    if (e !== 1'b0) begin errors++; $display("FAIL word_wr_addr_err got %b want 0", e); end
    if (rd !== 16'h0000) begin errors++; $display("FAIL word_wr_mdb_hold got %h want 0000", rd); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
    do_acc(1'b0, 1'b0, 16'h0200, 16'h0000, rd, e, lat, bc);
    checks += 3;
    if (rd !== 16'hBEEF) begin errors++; $display("FAIL word_rd_data got %h want BEEF", rd); end
    if (lat !== 3) begin errors++; $display("FAIL word_rd_latency got %0d want 3", lat); end
    if (bc !== 2) begin errors++; $display("FAIL word_rd_busy_cycles got %0d want 2", bc); end
  endtask

  task automatic test_byte();
    logic [15:0] rd; logic e; int lat; int bc;
    do_acc(1'b1, 1'b0, 16'h0200, 16'h1234, rd, e, lat, bc);
    do_acc(1'b1, 1'b1, 16'h0201, 16'hA55A, rd, e, lat, bc);
    do_acc(1'b0, 1'b0, 16'h0200, 16'h0000, rd, e, lat, bc);
    checks++;
    if (rd !== 16'h5A34) begin errors++; $display("FAIL byte_merge_word_rd got %h want 5A34", rd); end
    do_acc(1'b0, 1'b1, 16'h0201, 16'h0000, rd, e, lat, bc);
    checks++;
    if (rd !== 16'h005A) begin errors++; $display("FAIL byte_rd_hi got %h want 005A", rd); end
    do_acc(1'b0, 1'b1, 16'h0200, 16'h0000, rd, e, lat, bc);
    checks++;
    if (rd !== 16'h0034) begin errors++; $display("FAIL byte_rd_lo got %h want 0034", rd); end
  endtask

  task automatic test_addr_bit0();
    logic [15:0] rd; logic e; int lat; int bc;
    do_acc(1'b1, 1'b0, 16'h0202, 16'hCAFE, rd, e, lat, bc);
    do_acc(1'b0, 1'b0, 16'h0203, 16'h0000, rd, e, lat, bc);
    checks += 2;
    if (rd !== 16'hCAFE) begin errors++; $display("FAIL odd_word_rd got %h want CAFE", rd); end
    if (e !== 1'b0) begin errors++; $display("FAIL odd_word_addr_err got %b want 0", e); end
  endtask

  task automatic test_unmapped();
    logic [15:0] rd; logic e; int lat; int bc;
    do_acc(1'b0, 1'b0, 16'h0400, 16'h0000, rd, e, lat, bc);
    checks += 3;
    if (rd !== 16'h3FFF) begin errors++; $display("FAIL unmap_0400_data got %h want 3FFF", rd); end
    if (e !== 1'b1) begin errors++; $display("FAIL unmap_0400_addr_err got %b want 1", e); end
    if (lat !== 3) begin errors++; $display("FAIL unmap_0400_latency got %0d want 3", lat); end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL addr_err_one_cycle got %b want 0", err); end
    do_acc(1'b0, 1'b0, 16'h01FF, 16'h0000, rd, e, lat, bc);
    checks += 2;
    if (rd !== 16'h3FFF) begin errors++; $display("FAIL unmap_01FF_data got %h want 3FFF", rd); end
    if (e !== 1'b1) begin errors++; $display("FAIL unmap_01FF_addr_err got %b want 1", e); end
    do_acc(1'b0, 1'b1, 16'h0400, 16'h0000, rd, e, lat, bc);
    checks++;
    if (rd !== 16'h00FF) begin errors++; $display("FAIL unmap_byte_data got %h want 00FF", rd); end
    // Top of window is still mapped.
    do_acc(1'b1, 1'b0, 16'h03FE, 16'h1357, rd, e, lat, bc);
    do_acc(1'b0, 1'b1, 16'h03FF, 16'h0000, rd, e, lat, bc);
    checks += 2;
    if (rd !== 16'h0013) begin errors++; $display("FAIL last_byte_data got %h want 0013", rd); end
    if (e !== 1'b0) begin errors++; $display("FAIL last_byte_addr_err got %b want 0", e); end
    // Unmapped write must not alias into storage and must not touch MDB_out.
    do_acc(1'b1, 1'b0, 16'h0400, 16'hDEAD, rd, e, lat, bc);
    checks += 2;
    if (e !== 1'b1) begin errors++; $display("FAIL unmap_wr_addr_err got %b want 1", e); end
    if (rd !== 16'h0013) begin errors++; $display("FAIL unmap_wr_mdb_hold got %h want 0013", rd); end
    do_acc(1'b0, 1'b0, 16'h0200, 16'h0000, rd, e, lat, bc);
    checks++;
    if (rd !== 16'h5A34) begin errors++; $display("FAIL unmap_wr_0200 got %h want 5A34", rd); end
    do_acc(1'b0, 1'b0, 16'h0202, 16'h0000, rd, e, lat, bc);
    checks++;
    if (rd !== 16'hCAFE) begin errors++; $display("FAIL unmap_wr_0202 got %h want CAFE", rd); end
    do_acc(1'b0, 1'b0, 16'h03FE, 16'h0000, rd, e, lat, bc);
    checks++;
    if (rd !== 16'h1357) begin errors++; $display("FAIL unmap_wr_03FE got %h want 1357", rd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; logic e; int lat; int bc;
    logic want_done;
    // WAIT_STATES=0 with req held high: completion every other cycle.
    @(negedge clk);
    req0 = 1'b1; rw0 = 1'b1; md0 = 1'b0; mab0 = 16'h0200; mdb0 = 16'h1111;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      want_done = (i % 2 == 0);
      checks += 2;
      if (done0 !== want_done) begin errors++; $display("FAIL b2b_done cycle %0d got %b want %b", i, done0, want_done); end
      if (bsy0 !== !want_done) begin errors++; $display("FAIL b2b_busy cycle %0d got %b want %b", i, bsy0, !want_done); end
    end
    req0 = 1'b0;
    @(negedge clk);
    req0 = 1'b1; rw0 = 1'b0;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    checks += 2;
    if (done0 !== 1'b1) begin errors++; $display("FAIL ws0_rd_done got %b want 1", done0); end
    if (rdat0 !== 16'h1111) begin errors++; $display("FAIL ws0_rd_data got %h want 1111", rdat0); end

    // req raised while busy on the WAIT_STATES=1 instance must be dropped.
    do_acc(1'b1, 1'b0, 16'h0206, 16'h1111, rd, e, lat, bc);
    @(negedge clk);
    req = 1'b1; rw = 1'b1; md = 1'b0; mab = 16'h0204; mdb = 16'h7777;
    @(negedge clk);
    mab = 16'h0206; mdb = 16'h8888;
    checks++;
    if (bsy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b want 1", bsy); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL ignore_done got %b want 1", done); end
    req = 1'b0;
    do_acc(1'b0, 1'b0, 16'h0204, 16'h0000, rd, e, lat, bc);
    checks++;
    if (rd !== 16'h7777) begin errors++; $display("FAIL ignore_0204 got %h want 7777", rd); end
    do_acc(1'b0, 1'b0, 16'h0206, 16'h0000, rd, e, lat, bc);
    checks++;
    if (rd !== 16'h1111) begin errors++; $display("FAIL ignore_0206 got %h want 1111", rd); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] rd; logic e; int lat; int bc;
    do_acc(1'b1, 1'b0, 16'h0210, 16'hAAAA, rd, e, lat, bc);
    do_acc(1'b0, 1'b0, 16'h0210, 16'h0000, rd, e, lat, bc);
    checks++;
    if (rd !== 16'hAAAA) begin errors++; $display("FAIL abort_prior_rd got %h want AAAA", rd); end
    @(negedge clk);
    req = 1'b1; rw = 1'b1; md = 1'b0; mab = 16'h0210; mdb = 16'h5555;
    @(negedge clk);
    req = 1'b0;
    checks++;
    if (bsy !== 1'b1) begin errors++; $display("FAIL abort_in_wait got %b want 1", bsy); end
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (rdat !== 16'h0000) begin errors++; $display("FAIL abort_mdb_out got %h want 0000", rdat); end
    if (bsy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bsy); end
    if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_acc(1'b0, 1'b0, 16'h0210, 16'h0000, rd, e, lat, bc);
    checks += 2;
    if (rd !== 16'hAAAA) begin errors++; $display("FAIL abort_no_commit got %h want AAAA", rd); end
    if (lat !== 3) begin errors++; $display("FAIL abort_after_latency got %0d want 3", lat); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    req = 1'b0; mab = 16'h0000; mdb = 16'h0000; rw = 1'b0; md = 1'b0;
    req0 = 1'b0; mab0 = 16'h0000; mdb0 = 16'h0000; rw0 = 1'b0; md0 = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_addr_bit0();
    test_unmapped();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_resp.md
MEM_BUS_RESP -- requirements
Module: mem_bus_resp

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0200, byte address of the first mapped location.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, number of 16-bit storage words.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..15, extra cycles inserted before each access.
REQ-004 SHALL have one clock and an asynchronous active-low reset: ports clk and rst_n.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- clk      input   1   rising-edge clock
- rst_n    input   1   asynchronous active-low reset
- req      input   1   access request strobe, sampled only in IDLE
- MAB_in   input   16  byte address from the address-bus mux
- MDB_in   input   16  write data
- RW       input   1   1 = write, 0 = read
- MD       input   1   1 = byte access, 0 = word access
- MDB_out  output  16  read data, registered
- mem_done output  1   one-cycle completion pulse
- busy     output  1   access in progress
- addr_err output  1   one-cycle pulse, coincident with mem_done, for an unmapped address

Function
REQ-006 SHALL implement states IDLE, WAIT, ACCESS.
REQ-007 IDLE with req=1 at an edge SHALL latch MAB_in, MDB_in, RW and MD, and set the wait counter to WAIT_STATES.
- Next state is WAIT if WAIT_STATES>0, else ACCESS.
REQ-008 WAIT SHALL decrement the counter each cycle and go to ACCESS on the edge where the counter equals 1.
REQ-009 ACCESS SHALL last exactly one cycle.
- At its closing edge: commit the write or load MDB_out, set mem_done=1, go to IDLE.
REQ-010 Latency: if req is sampled at edge E0, mem_done SHALL be high for exactly the cycle following edge E0+WAIT_STATES+1.
REQ-011 busy SHALL be 1 from edge E0 until the edge that raises mem_done.
- busy SHALL be 0 while mem_done is high, so a back-to-back req is accepted in that cycle.
REQ-012 req while busy=1 SHALL be ignored and SHALL NOT change the latched operands.
REQ-013 Mapping: an address is mapped when BASE_ADDR <= addr <= BASE_ADDR + 2*DEPTH_WORDS - 1, compared as 16-bit unsigned with no wrap.
- Word index = (addr - BASE_ADDR) >> 1.
REQ-014 Word access SHALL ignore address bit 0.
- Read: MDB_out = stored word.
- Write: store all 16 bits of MDB_in.
REQ-015 Byte access SHALL select the lane by address bit 0 (0 = low byte, 1 = high byte).
- Read: MDB_out = {8'h00, selected byte}.
- Write: store MDB_in[7:0] into the selected lane only; the other lane is unchanged.
REQ-016 Unmapped read SHALL return MDB_out = 16'h3FFF for a word access and 16'h00FF for a byte access.
REQ-017 Unmapped write SHALL modify no storage.
REQ-018 Every unmapped access SHALL pulse addr_err together with mem_done.
REQ-019 MDB_out SHALL hold its value between reads and SHALL NOT change on a write.
REQ-020 Storage contents SHALL NOT be reset and are undefined until written.

Reset
REQ-021 rst_n=0 SHALL immediately force: state IDLE, counter 0, MDB_out 16'h0000, mem_done 0, busy 0, addr_err 0.
REQ-022 Reset asserted before the ACCESS closing edge SHALL abort the access with no write committed.
REQ-023 After rst_n deasserts, the first req SHALL be sampled no earlier than the first rising clk edge with rst_n=1.

Verification
REQ-024 Word write 16'hBEEF to 16'h0200, then word read 16'h0200 (WAIT_STATES=1) -> MDB_out=16'hBEEF; mem_done high in the 3rd cycle after req sampled; busy=1 for 2 cycles.
REQ-025 Byte write 8'h5A to 16'h0201 over word 16'h1234 at 16'h0200, then word read -> 16'h5A34; byte read 16'h0201 -> 16'h005A.
REQ-026 Word read at 16'h0203 after word write 16'hCAFE to 16'h0202 -> 16'hCAFE; addr_err=0.
REQ-027 Word read at 16'h0400 and 16'h01FF -> 16'h3FFF with addr_err pulsing with mem_done; a write to 16'h0400 leaves all storage unchanged.
REQ-028 WAIT_STATES=0 back-to-back reqs held high -> mem_done on alternate cycles; a req raised while busy=1 is ignored.
REQ-029 rst_n pulsed low during WAIT of a write to 16'h0210 -> outputs zero immediately; a later read of 16'h0210 returns the prior contents.
